updown_counter_mod: RTL

//  Parametrised up/down counter: programmable modulus, variable step, wrap or saturate mode.

---
 rtl/counter_pkg.sv | 63 ++++++
 rtl/updown_counter_step.sv | 32 +++
 rtl/updown_counter_mod.sv | 111 +++++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter: mode selectors and the
// next-count helper used by the step sub-module.
package counter_pkg;

    // Values for the SATURATE parameter.
    localparam int CNT_WRAP = 0;
    localparam int CNT_SAT  = 1;

    // Working width of the helper. Callers zero-extend into it, so any
    // counter up to 31 bits wide computes without intermediate truncation.
    localparam int CNT_FN_W = 32;

    typedef logic [CNT_FN_W-1:0] cnt_word_t;

    // Returns {next, wrap}. next always lies in 0..max, even when step > max.
    function automatic logic [CNT_FN_W:0] cnt_next(
        input cnt_word_t count,
        input cnt_word_t step,
        input logic      up,
        input cnt_word_t max,
        input logic      sat
    );
        logic [CNT_FN_W:0] w_cnt;
        logic [CNT_FN_W:0] w_stp;
        logic [CNT_FN_W:0] w_max;
        logic [CNT_FN_W:0] w_mod;
        logic [CNT_FN_W:0] w_sum;
        logic [CNT_FN_W:0] w_nxt;
        logic              w_wrap;

        w_cnt  = {1'b0, count};
        w_stp  = {1'b0, step};
        w_max  = {1'b0, max};
        w_mod  = w_max + (CNT_FN_W+1)'(1);
        w_sum  = w_cnt + w_stp;
        w_nxt  = w_cnt;
        w_wrap = 1'b0;

        if (up) begin
            if (w_sum <= w_max) begin
                w_nxt = w_sum;
            end else begin
                w_wrap = 1'b1;
                w_nxt  = sat ? w_max : (w_sum - w_mod);
            end
        end else begin
            if (w_cnt >= w_stp) begin
                w_nxt = w_cnt - w_stp;
            end else begin
                w_wrap = 1'b1;
                w_nxt  = sat ? '0 : (w_cnt + w_mod - w_stp);
            end
        end

        // Only reachable with step > max; keeps the count in range regardless.
        if (w_nxt > w_max) begin
            w_nxt = w_max;
        end

        return {w_nxt[CNT_FN_W-1:0], w_wrap};
    endfunction

endpackage

// File: rtl/updown_counter_step.sv
// Combinational next-count stage: applies one up/down step to the current
// count and reports whether that step wrapped (or clamped in saturate mode).
module updown_counter_step
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int SATURATE = 0
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic [WIDTH-1:0] i_step,
    input  logic             i_up_down,
    output logic [WIDTH-1:0] o_next,
    output logic             o_wrap
);

    localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_VAL);
    localparam logic             SAT_MODE = (SATURATE == CNT_SAT);

    logic [CNT_FN_W:0] w_res;
    logic              w_hi_set;

    assign w_res = cnt_next(cnt_word_t'(i_count), cnt_word_t'(i_step), i_up_down,
                            cnt_word_t'(MAX_C), SAT_MODE);

    // The helper's word is wider than the counter; any set bit above the
    // counter width means out of range, so it folds into the same clamp.
    assign w_hi_set = |w_res[CNT_FN_W:WIDTH+1];
    assign o_next   = w_hi_set ? MAX_C : w_res[WIDTH:1];
    assign o_wrap   = w_res[0];

endmodule

// File: rtl/updown_counter_mod.sv
// Up/down counter with programmable modulus, variable step, wrap or saturate
// mode, range-checked load, terminal flags, event pulses and a sticky ovf.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = 2**WIDTH-1,
    parameter int SATURATE = CNT_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             up_down,
    input  logic [WIDTH-1:0] step,
    input  logic             clr_flag,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             wrap,
    output logic             load_err,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_C      = WIDTH'(MAX_VAL);
    localparam bit               FULL_RANGE = (MAX_VAL == (2**WIDTH)-1);

    logic [WIDTH-1:0] r_count;
    logic             r_at_max;
    logic             r_at_min;
    logic             r_wrap;
    logic             r_load_err;
    logic             r_ovf;

    logic [WIDTH-1:0] w_step_next;
    logic             w_step_wrap;
    logic             w_load_over;
    logic [WIDTH-1:0] w_next_count;
    logic             w_next_wrap;
    logic             w_next_load_err;

    updown_counter_step #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .SATURATE (SATURATE)
    ) u_step (
        .i_count   (r_count),
        .i_step    (step),
        .i_up_down (up_down),
        .o_next    (w_step_next),
        .o_wrap    (w_step_wrap)
    );

    // With a full-range modulus no load value can exceed MAX_VAL.
    generate
        if (FULL_RANGE) begin : g_full_range
            assign w_load_over = 1'b0;
        end else begin : g_part_range
            assign w_load_over = (data > MAX_C);
        end
    endgenerate

    // Select the next count and event pulses: load beats counting, idle holds.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        w_next_count    = r_count;
        w_next_wrap     = 1'b0;
        w_next_load_err = 1'b0;
        if (load) begin
            w_next_count    = w_load_over ? MAX_C : data;
            w_next_load_err = w_load_over;
        end else if (en) begin
            w_next_count = w_step_next;
            w_next_wrap  = w_step_wrap;
        end
    end

    // Register count and all flags on the same edge; reset wins over everything.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_count    <= '0;
            r_at_max   <= 1'b0;
            r_at_min   <= 1'b1;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_count    <= w_next_count;
            r_at_max   <= (w_next_count == MAX_C);
            r_at_min   <= (w_next_count == '0);
            r_wrap     <= w_next_wrap;
            r_load_err <= w_next_load_err;
            // A new event sets ovf even when a clear is requested in the same cycle.
            if (w_next_wrap || w_next_load_err) begin
                r_ovf <= 1'b1;
            end else if (clr_flag) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign count    = r_count;
    assign at_max   = r_at_max;
    assign at_min   = r_at_min;
    assign wrap     = r_wrap;
    assign load_err = r_load_err;
    assign ovf      = r_ovf;

endmodule
